// File: rtl/bram_pwr_seq.sv
// Run sequencer and result collector for an array of BRAM power-test DUTs:
// staged enable ramp, settle window, timed pass-flag sampling and verdict.
module bram_pwr_seq #(
    parameter int N_DUT      = 8,
    parameter int STAGE_CYC  = 4,
    parameter int SETTLE_CYC = 16,
    parameter int RUN_W      = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               go,
    input  logic               abort,
    input  logic [RUN_W-1:0]   run_len,
    output logic [N_DUT-1:0]   dut_start,
    output logic [N_DUT-1:0]   dut_enable,
    input  logic [N_DUT-1:0]   dut_pass,
    output logic               busy,
    output logic               done,
    output logic               all_pass,
    output logic               aborted,
    output logic [N_DUT-1:0]   fail_mask,
    output logic [15:0]        fail_cnt
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RAMP   = 3'd1,
        S_SETTLE = 3'd2,
        S_CHECK  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam int CNT_MAX = (STAGE_CYC > SETTLE_CYC) ? STAGE_CYC : SETTLE_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] STAGE_LAST  = CNT_W'(STAGE_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [N_DUT-1:0] BIT0        = N_DUT'(1'b1);
    localparam logic [N_DUT-1:0] ALL_ONES    = {N_DUT{1'b1}};

    state_t             state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [RUN_W-1:0]   rem_r;
    logic               run_active_s;

    assign run_active_s = (state_r == S_RAMP) || (state_r == S_SETTLE) || (state_r == S_CHECK);

    // Enable and start are the same registered vector by contract.
    assign dut_enable = dut_start;

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= S_IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            rem_r     <= {RUN_W{1'b0}};
            dut_start <= {N_DUT{1'b0}};
            busy      <= 1'b0;
            done      <= 1'b0;
            all_pass  <= 1'b0;
            aborted   <= 1'b0;
            fail_mask <= {N_DUT{1'b0}};
            fail_cnt  <= 16'h0000;
        end else if (abort && run_active_s) begin
            // The abort cycle's pass flags are deliberately not sampled.
            state_r  <= S_DONE;
            done     <= 1'b1;
            all_pass <= 1'b0;
            aborted  <= 1'b1;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (go && !abort) begin
                        fail_mask <= {N_DUT{1'b0}};
                        fail_cnt  <= 16'h0000;
                        all_pass  <= 1'b0;
                        aborted   <= 1'b0;
                        rem_r     <= (run_len == {RUN_W{1'b0}}) ? RUN_W'(1'b1) : run_len;
                        dut_start <= BIT0;
                        busy      <= 1'b1;
                        cnt_r     <= {CNT_W{1'b0}};
                        state_r   <= S_RAMP;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_RAMP: begin
                    if (dut_start[N_DUT-1]) begin
                        cnt_r   <= {CNT_W{1'b0}};
                        state_r <= S_SETTLE;
                    end else if (cnt_r == STAGE_LAST) begin
                        dut_start <= (dut_start << 1) | BIT0;
                        cnt_r     <= {CNT_W{1'b0}};
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1'b1);
                    end
                end
                S_SETTLE: begin
                    if (cnt_r == SETTLE_LAST) begin
                        state_r <= S_CHECK;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1'b1);
                    end
                end
                S_CHECK: begin
                    fail_mask <= fail_mask | ~dut_pass;
                    if ((dut_pass != ALL_ONES) && (fail_cnt != 16'hFFFF)) begin
                        fail_cnt <= fail_cnt + 16'd1;
                    end
                    if (rem_r == RUN_W'(1'b1)) begin
                        state_r  <= S_DONE;
                        done     <= 1'b1;
                        all_pass <= ((fail_mask | ~dut_pass) == {N_DUT{1'b0}});
                    end else begin
                        rem_r <= rem_r - RUN_W'(1'b1);
                    end
                end
                S_DONE: begin
                    state_r   <= S_IDLE;
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    dut_start <= {N_DUT{1'b0}};
                end
                default: begin
                    state_r   <= S_IDLE;
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    dut_start <= {N_DUT{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bram_pwr_seq.sv
// Scoreboard bench for bram_pwr_seq: expected run results are queued at go
// and popped when the done pulse appears; per-cycle outputs follow the timing contract.
module tb_bram_pwr_seq;

    localparam int N   = 8;
    localparam int S   = 4;
    localparam int SET = 16;
    localparam int C0  = 2 + (N - 1) * S + SET;

    logic          clk = 1'b0;
    logic          rst, go, abort;
    logic [15:0]   run_len;
    logic [N-1:0]  dut_start, dut_enable, dut_pass, fail_mask;
    logic          busy, done, all_pass, aborted;
    logic [15:0]   fail_cnt;

    typedef struct {
        int           done_cyc;
        logic         all_pass;
        logic         aborted;
        logic [N-1:0] mask;
        logic [15:0]  cnt;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;

    bram_pwr_seq #(.N_DUT(N), .STAGE_CYC(S), .SETTLE_CYC(SET), .RUN_W(16)) dut (
        .clk(clk), .rst(rst), .go(go), .abort(abort), .run_len(run_len),
        .dut_start(dut_start), .dut_enable(dut_enable), .dut_pass(dut_pass),
        .busy(busy), .done(done), .all_pass(all_pass), .aborted(aborted),
        .fail_mask(fail_mask), .fail_cnt(fail_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [N-1:0] pass_at(input int c, input int fbit, input int flo, input int fhi);
        logic [N-1:0] p;
        if (c < 40) return {N{1'b0}};
        p = {N{1'b1}};
        if (fbit >= 0 && c >= flo && c <= fhi) p[fbit] = 1'b0;
        return p;
    endfunction

    // One run with go at cycle 0; negative arguments disable abort/fault/reset/extra go.
    task automatic run(input int len, input int abort_at, input int fbit, input int flo,
                       input int fhi, input int rst_at, input int go2_at);
        int           L, exp_done, end_c;
        exp_t         e, got;
        logic [N-1:0] pm, exp_en, rmask;
        logic [15:0]  rcnt;
        logic         killed;

        L        = (len == 0) ? 1 : len;
        exp_done = (abort_at >= 0) ? abort_at + 1 : C0 + L;
        e.mask   = {N{1'b0}};
        e.cnt    = 16'h0000;
        for (int c = C0; c < C0 + L; c++) begin
            if (abort_at >= 0 && c >= abort_at) break;
            pm = pass_at(c, fbit, flo, fhi);
            e.mask |= ~pm;
            if (pm != {N{1'b1}} && e.cnt != 16'hFFFF) e.cnt++;
        end
        e.all_pass = (abort_at < 0) && (e.mask == {N{1'b0}});
        e.aborted  = (abort_at >= 0);
        e.done_cyc = exp_done;
        if (rst_at < 0) sb.push_back(e);
        end_c = (rst_at >= 0) ? rst_at + 1 : exp_done + 1;

        cyc      = 0;
        run_len  = len[15:0];
        go       = 1'b1;
        abort    = 1'b0;
        rst      = 1'b0;
        dut_pass = pass_at(0, fbit, flo, fhi);
        rmask    = {N{1'b0}};
        rcnt     = 16'h0000;

        for (int c = 1; c <= end_c; c++) begin
            tick();
            killed = (rst_at >= 0) && (c > rst_at);
            exp_en = {N{1'b0}};
            if (!killed && c <= exp_done)
                for (int i = 0; i < N; i++)
                    if (1 + i * S <= c && (abort_at < 0 || 1 + i * S <= abort_at)) exp_en[i] = 1'b1;
            check_val("dut_start", dut_start, exp_en);
            check_val("dut_enable", dut_enable, exp_en);
            check_val("busy", busy, !killed && c <= exp_done);
            check_val("done", done, !killed && c == exp_done);
            check_val("fail_cnt_run", fail_cnt, killed ? 16'h0000 : rcnt);
            check_val("fail_mask_run", fail_mask, killed ? {N{1'b0}} : rmask);
            if (c == 1 || killed) begin
                check_val("aborted_clear", aborted, 1'b0);
                check_val("all_pass_clear", all_pass, 1'b0);
            end
            if (done) begin
                if (sb.size() == 0) begin
                    check_val("done_unexpected", done, 1'b0);
                end else begin
                    got = sb.pop_front();
                    check_val("done_cycle", c, got.done_cyc);
                    check_val("all_pass", all_pass, got.all_pass);
                    check_val("aborted", aborted, got.aborted);
                    check_val("fail_mask", fail_mask, got.mask);
                    check_val("fail_cnt", fail_cnt, got.cnt);
                end
            end
            go       = (c == go2_at);
            abort    = (c == abort_at);
            rst      = (c == rst_at);
            dut_pass = pass_at(c, fbit, flo, fhi);
            if (c >= C0 && c < C0 + L && (abort_at < 0 || c < abort_at) && (rst_at < 0 || c < rst_at)) begin
                rmask |= ~dut_pass;
                if (dut_pass != {N{1'b1}} && rcnt != 16'hFFFF) rcnt++;
            end
        end
        go    = 1'b0;
        abort = 1'b0;
        rst   = 1'b0;
        if (sb.size() != 0) begin
            check_val("done_missing", sb.size(), 0);
            sb.delete();
        end
    endtask

    initial begin
        rst      = 1'b1;
        go       = 1'b0;
        abort    = 1'b0;
        run_len  = 16'h0000;
        dut_pass = {N{1'b0}};
        tick();
        tick();
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_done", done, 1'b0);
        check_val("rst_all_pass", all_pass, 1'b0);
        check_val("rst_aborted", aborted, 1'b0);
        check_val("rst_start", dut_start, {N{1'b0}});
        check_val("rst_enable", dut_enable, {N{1'b0}});
        check_val("rst_fail_mask", fail_mask, {N{1'b0}});
        check_val("rst_fail_cnt", fail_cnt, 16'h0000);
        rst = 1'b0;
        tick();

        run(100, -1, -1, 0, 0, -1, -1);          // clean pass
        tick();
        run(100, -1, 3, 60, 64, -1, -1);         // transient fail on DUT 3
        tick();
        run(100, 20, -1, 0, 0, -1, -1);          // abort during ramp
        tick();
        run(0, -1, -1, 0, 0, -1, 30);            // zero length, stray go ignored
        tick();
        run(100, 80, 2, 79, 85, -1, -1);         // abort during check
        tick();

        go    = 1'b1;                            // abort beats go in idle
        abort = 1'b1;
        tick();
        go    = 1'b0;
        abort = 1'b0;
        check_val("go_abort_busy", busy, 1'b0);
        check_val("go_abort_start", dut_start, {N{1'b0}});
        tick();
        check_val("go_abort_busy2", busy, 1'b0);

        run(100, -1, -1, 0, 0, 50, -1);          // reset mid-check
        tick();
        run(100, -1, -1, 0, 0, -1, -1);          // normal run after reset
        tick();
        run(16'hFFFF, -1, 0, 0, 32'h7FFFFFFF, -1, -1);  // saturating count

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
